// File: rtl/calc2_port_initiator.sv
// Request-side initiator for one calc2 port: allocates one of four tags, drives the
// two-beat command/operand sequence and retires tags on matching responses or timeout.
module calc2_port_initiator #(
    parameter int TIMEOUT = 64,
    localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_cmd,
    input  logic [31:0] op_data1,
    input  logic [31:0] op_data2,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    output logic [1:0]  req_tag_out,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    input  logic [1:0]  out_tag,
    output logic        rsp_valid,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic        rsp_timeout,
    output logic        err_unexp,
    output logic [3:0]  busy_tags,
    output logic        dbg_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SEND2 = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_busy;
    logic [3:0]       w_busy_nxt;
    logic [CNT_W-1:0] r_cnt [4];
    logic [31:0]      r_op_data2;

    logic             r_op_ready;
    logic             w_op_ready_nxt;
    logic [3:0]       r_req_cmd;
    logic [3:0]       w_req_cmd_nxt;
    logic [31:0]      r_req_data;
    logic [31:0]      w_req_data_nxt;
    logic [1:0]       r_req_tag;
    logic [1:0]       w_req_tag_nxt;

    logic             r_rsp_valid;
    logic [1:0]       r_rsp_resp;
    logic [31:0]      r_rsp_data;
    logic [1:0]       r_rsp_tag;
    logic             r_rsp_timeout;
    logic             r_err_unexp;

    logic             w_accept;
    logic             w_has_free;
    logic [1:0]       w_free_tag;
    logic [3:0]       w_expired;
    logic [1:0]       w_to_tag;
    logic             w_to_valid;
    logic             w_rsp_hit;
    logic             w_rsp_miss;

    // Upstream handshake: an operation transfers on a rising edge where op_valid and
    // op_ready are both high; op_ready is a registered view of "idle with a free tag".
    assign w_accept   = (r_state == ST_IDLE) && r_op_ready && op_valid && w_has_free;
    assign w_rsp_hit  = (out_resp != 2'b00) && r_busy[out_tag];
    assign w_rsp_miss = (out_resp != 2'b00) && !r_busy[out_tag];
    assign w_to_valid = !w_rsp_hit && (|w_expired);

    // Lowest-index free tag and lowest-index expired tag.
    always_comb begin
        w_has_free = 1'b0;
        w_free_tag = 2'd0;
        w_expired  = 4'd0;
        w_to_tag   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_has_free = 1'b1;
                w_free_tag = 2'(i);
            end
            if (r_busy[i] && (r_cnt[i] == CNT_MAX)) begin
                w_expired[i] = 1'b1;
                w_to_tag     = 2'(i);
            end
        end
    end

    // Allocation reads r_busy, so a tag freed on this edge is never reused on it.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_rsp_hit) begin
            w_busy_nxt[out_tag] = 1'b0;
        end else if (w_to_valid) begin
            w_busy_nxt[w_to_tag] = 1'b0;
        end
        if (w_accept) begin
            w_busy_nxt[w_free_tag] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_req_cmd_nxt  = 4'd0;
        w_req_data_nxt = 32'd0;
        w_req_tag_nxt  = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = ST_SEND2;
                    w_req_cmd_nxt  = op_cmd;
                    w_req_data_nxt = op_data1;
                    w_req_tag_nxt  = w_free_tag;
                end
            end
            ST_SEND2: begin
                w_state_nxt    = ST_IDLE;
                w_req_data_nxt = r_op_data2;
                w_req_tag_nxt  = r_req_tag;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_op_ready_nxt = (w_state_nxt == ST_IDLE) && (w_busy_nxt != 4'hF);
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 4'd0;
            r_op_data2 <= 32'd0;
            r_op_ready <= 1'b0;
            r_req_cmd  <= 4'd0;
            r_req_data <= 32'd0;
            r_req_tag  <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_op_ready <= w_op_ready_nxt;
            r_req_cmd  <= w_req_cmd_nxt;
            r_req_data <= w_req_data_nxt;
            r_req_tag  <= w_req_tag_nxt;
            if (w_accept) begin
                r_op_data2 <= op_data2;
            end
        end
    end

    // Counters saturate at TIMEOUT; a stale value on a freed tag is cleared on reallocation.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_accept && (w_free_tag == 2'(i))) begin
                    r_cnt[i] <= '0;
                end else if (r_busy[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_resp    <= 2'd0;
            r_rsp_data    <= 32'd0;
            r_rsp_tag     <= 2'd0;
            r_rsp_timeout <= 1'b0;
            r_err_unexp   <= 1'b0;
        end else begin
            r_err_unexp <= w_rsp_miss;
            if (w_rsp_hit) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_resp    <= out_resp;
                r_rsp_data    <= out_data;
                r_rsp_tag     <= out_tag;
                r_rsp_timeout <= 1'b0;
            end else if (w_to_valid) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_resp    <= 2'd0;
                r_rsp_data    <= 32'd0;
                r_rsp_tag     <= w_to_tag;
                r_rsp_timeout <= 1'b1;
            end else begin
                r_rsp_valid   <= 1'b0;
                r_rsp_resp    <= 2'd0;
                r_rsp_data    <= 32'd0;
                r_rsp_tag     <= 2'd0;
                r_rsp_timeout <= 1'b0;
            end
        end
    end

    assign op_ready     = r_op_ready;
    assign req_cmd_out  = r_req_cmd;
    assign req_data_out = r_req_data;
    assign req_tag_out  = r_req_tag;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_resp     = r_rsp_resp;
    assign rsp_data     = r_rsp_data;
    assign rsp_tag      = r_rsp_tag;
    assign rsp_timeout  = r_rsp_timeout;
    assign err_unexp    = r_err_unexp;
    assign busy_tags    = r_busy;
    assign dbg_state    = r_state;

endmodule

// File: doc/calc2_port_initiator.md
# calc2_port_initiator

Request-side initiator for one calc2 port. It takes operations from an upstream valid/ready source, allocates one of four tags, and drives the two-cycle calc2 command/operand sequence. It tracks outstanding tags, matches returning responses by tag, and reports completions or per-tag timeouts on a single result stream. One instance sits in front of each of the four calc2 request ports.

## Interface
- TIMEOUT, 64: cycles a tag may stay outstanding before it is retired as timed out; legal range 2..65535.
- CNT_W, $clog2(TIMEOUT+1): width of the per-tag timeout counters (derived, do not override).

Ports:
- c_clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  upstream operation valid.
- op_ready  out  1  upstream handshake; an operation is accepted when op_valid && op_ready.
- op_cmd  in  4  calc2 command (1 add, 2 sub, 5 shl, 6 shr; other values forwarded unchanged).
- op_data1  in  32  operand 1.
- op_data2  in  32  operand 2.
- req_cmd_out  out  4  to the calc2 reqN_cmd_in.
- req_data_out  out  32  to the calc2 reqN_data_in.
- req_tag_out  out  2  to the calc2 reqN_tag_in.
- out_resp  in  2  from calc2 out_respN; non-zero marks a valid response.
- out_data  in  32  from calc2 out_dataN.
- out_tag  in  2  from calc2 out_tagN.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_resp  out  2  response code; 2'b00 when rsp_timeout is set.
- rsp_data  out  32  result data; 0 when rsp_timeout is set.
- rsp_tag  out  2  tag being completed.
- rsp_timeout  out  1  the completion is a timeout, not a DUT response.
- err_unexp  out  1  one-cycle pulse: a response arrived for a tag that is not outstanding.
- busy_tags  out  4  outstanding-tag bitmap.

## Operation
- Reset values: all outputs 0, state IDLE, busy_tags 0, all counters 0.
- FSM states:
  - IDLE: op_ready = (busy_tags != 4'hF).
  - SEND2: op_ready = 0.
- Acceptance in IDLE:
  - Allocate the lowest-index free tag and set its busy bit.
  - Load req_cmd_out=op_cmd, req_data_out=op_data1, req_tag_out=tag; go to SEND2.
- SEND2 (one cycle): req_cmd_out=0, req_data_out=op_data2, req_tag_out held. Return to IDLE.
- IDLE without acceptance: req_cmd_out=0, req_data_out=0, req_tag_out=0.
- A tag freed in cycle N becomes allocatable in cycle N+1; allocation never picks a tag that is being freed in the same cycle.
- Response capture, when out_resp != 0:
  - If busy_tags[out_tag] is set: clear it and register resp/data/tag onto rsp_* with rsp_valid=1, rsp_timeout=0.
  - Otherwise: pulse err_unexp, emit no rsp_valid, and leave state unchanged.
- Timeout counters:
  - A tag's counter clears on allocation and increments each cycle while the tag is busy.
  - On reaching TIMEOUT the counter saturates. The tag is retired, with rsp_valid=1, rsp_timeout=1, rsp_tag=tag, rsp_resp=0, rsp_data=0, only in a cycle with no DUT response capture.
  - If several tags are expired at once, the lowest index retires first; the rest retire on later cycles.
- Priority on the single result port: DUT response first, then timeout.
  - If a response for a tag arrives in the same cycle that tag expires, the response wins and no timeout is reported for it.
  - A late response after a timeout retire is reported as err_unexp.
- The block does not interpret response codes or op_cmd; invalid commands are forwarded unchanged.
- Reset mid-operation: an in-flight SEND2 is abandoned, all tags are freed, and no rsp_valid or err_unexp is generated for abandoned tags.

## Timing
- All outputs are registered.
- Acceptance at edge N: command beat on req_* during cycle N+1, operand beat during N+2. The earliest next acceptance is the edge ending N+2, giving one command every 2 cycles at full throughput.
- Response sampled at edge M: rsp_valid or err_unexp is high during cycle M+1 for exactly 1 cycle.
- Timeout retire happens no earlier than TIMEOUT cycles after the command beat.
- busy_tags updates the cycle after the allocating or freeing edge.

## Test plan
- Single add: op_cmd=1, op_data1=5, op_data2=7. Required: req beats (1,5,tag0) then (0,7,tag0). A response of resp=1, data=12, tag=0 gives rsp_valid with resp=1, data=12, tag=0, and busy_tags returns to 0.
- Issue four operations back to back with no responses. Required: tags 0,1,2,3 in order, op_ready=0 with busy_tags=F. A response on tag 2 lets the next acceptance allocate tag 2.
- Out-of-order responses on tags 3,0,1,2. Required: each completion carries the matching data and tag, and no err_unexp.
- TIMEOUT=8 with no response on tag 0. Required: rsp_timeout pulse with tag 0, resp=0, data=0. A later response on tag 0 gives err_unexp=1 and no rsp_valid.
- Simultaneous events: a response for tag 1 in the same cycle tag 0 expires. Required: tag 1 completes first and the tag 0 timeout follows the next cycle. A response for the expiring tag itself gives a response completion only.
- Assert reset during SEND2 with two tags busy. Required: all outputs 0, busy_tags=0, and op_ready=1 after release. A later response for an old tag gives err_unexp.
